// File: rtl/seg_scan_pkg.sv
// Shared constants and state type for the seven-segment scan controller.
package seg_scan_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned SEL_W      = 3;
  localparam int unsigned NIB_W      = 4;

  typedef enum logic {
    S_IDLE,
    S_SCAN
  } scan_state_t;

endpackage

// File: rtl/scan_prescaler.sv
// Slot prescaler: counts SCAN_DIV cycles per digit slot while run is high.
module scan_prescaler #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] pcnt;

  // Count 0..SCAN_DIV-1 while running, otherwise hold at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (!run || (pcnt == LAST)) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + CNT_W'(1);
    end
  end

  assign tick = run && (pcnt == LAST);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// Optional feature macro: SEG_SCAN_LZ_BLANK_EN (leading-zero suppression).
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [31:0]      digits,
  input  logic [7:0]       dp_in,
  input  logic [7:0]       blank_mask,
  output logic [SEL_W-1:0] digit_sel,
  output logic [NIB_W-1:0] nibble,
  output logic             dp,
  output logic             blank,
  output logic             tick,
  output logic             frame_done
);

  scan_state_t      state;
  scan_state_t      state_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic             blank_nxt;
  logic             run;
  logic             slot_end;

  assign run = (state == S_SCAN);

  scan_prescaler #(
    .SCAN_DIV(SCAN_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .run (run),
    .tick(slot_end)
  );

  assign tick       = slot_end;
  assign frame_done = slot_end && (digit_sel == SEL_W'(NUM_DIGITS - 1));

`ifdef SEG_SCAN_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;
  logic                  zero_above;

  // Digit k>=1 is suppressed when it and every higher nibble are zero and its dp is off.
  always_comb begin
    lz         = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (digits[4*k +: NIB_W] == '0);
      lz[k]      = zero_above && !dp_in[k];
    end
  end
`endif

  // Next state, next index and next blank flag; IDLE wins over a coincident tick.
  always_comb begin
    state_nxt = en ? S_SCAN : S_IDLE;
    sel_nxt   = digit_sel;
    if (slot_end && en) begin
      sel_nxt = digit_sel + SEL_W'(1);
    end
`ifdef SEG_SCAN_LZ_BLANK_EN
    blank_nxt = (state_nxt == S_IDLE) || blank_mask[sel_nxt] || lz[sel_nxt];
`else
    blank_nxt = (state_nxt == S_IDLE) || blank_mask[sel_nxt];
`endif
  end

  // FSM, digit index and per-digit output registers aligned with the new index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      digit_sel <= '0;
      nibble    <= '0;
      dp        <= 1'b0;
      blank     <= 1'b1;
    end else begin
      state     <= state_nxt;
      digit_sel <= sel_nxt;
      nibble    <= digits[{sel_nxt, 2'b00} +: NIB_W];
      dp        <= dp_in[sel_nxt];
      blank     <= blank_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: SCAN_DIV=4 and SCAN_DIV=1 instances against a slot-level model.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] digits = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  blank_mask = '0;

  logic [2:0] sel4, sel1;
  logic [3:0] nib4, nib1;
  logic       dp4, dp1, blank4, blank1, tick4, tick1, frame4, frame1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.SCAN_DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .en(en), .digits(digits), .dp_in(dp_in),
    .blank_mask(blank_mask), .digit_sel(sel4), .nibble(nib4), .dp(dp4),
    .blank(blank4), .tick(tick4), .frame_done(frame4)
  );

  seg_scan_ctrl #(.SCAN_DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .en(en), .digits(digits), .dp_in(dp_in),
    .blank_mask(blank_mask), .digit_sel(sel1), .nibble(nib1), .dp(dp1),
    .blank(blank1), .tick(tick1), .frame_done(frame1)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  // Reference: scanning flag, position inside the slot, current digit.
  int   div   [2] = '{4, 1};
  bit   m_scan[2] = '{0, 0};
  int   m_pos [2] = '{0, 0};
  int   m_sel [2] = '{0, 0};
  logic [3:0] m_nib[2] = '{4'h0, 4'h0};
  logic m_dp   [2] = '{1'b0, 1'b0};
  logic m_blank[2] = '{1'b1, 1'b1};

  function automatic bit lz_sup(input int k, input logic [31:0] d, input logic [7:0] p);
`ifdef SEG_SCAN_LZ_BLANK_EN
    return (k != 0) && ((d >> (4 * k)) == 32'd0) && !p[k];
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_scan[i] = 0; m_pos[i] = 0; m_sel[i] = 0;
        m_nib[i] = 4'h0; m_dp[i] = 1'b0; m_blank[i] = 1'b1;
      end else begin
        if (m_scan[i] && en && (m_pos[i] == div[i] - 1)) m_sel[i] = (m_sel[i] + 1) % 8;
        m_pos[i]   = (m_scan[i] && en) ? (m_pos[i] + 1) % div[i] : 0;
        m_scan[i]  = en;
        m_nib[i]   = 4'((digits >> (4 * m_sel[i])) & 32'hF);
        m_dp[i]    = dp_in[m_sel[i]];
        m_blank[i] = !en || blank_mask[m_sel[i]] || lz_sup(m_sel[i], digits, dp_in);
      end
    end
  end

  task automatic cmp_inst(input int i, input string nm, input logic [2:0] s, input logic [3:0] n,
                          input logic d, input logic b, input logic t, input logic f);
    logic exp_tick;
    exp_tick = m_scan[i] && (m_pos[i] == div[i] - 1);
    chk({nm, "_sel"},   32'(s), 32'(m_sel[i]));
    chk({nm, "_nib"},   32'(n), 32'(m_nib[i]));
    chk({nm, "_dp"},    32'(d), 32'(m_dp[i]));
    chk({nm, "_blank"}, 32'(b), 32'(m_blank[i]));
    chk({nm, "_tick"},  32'(t), 32'(exp_tick));
    chk({nm, "_frame"}, 32'(f), 32'(exp_tick && (m_sel[i] == 7)));
  endtask

  // Compare both instances against the model shortly after every rising edge.
  always @(posedge clk) begin
    #2;
    cmp_inst(0, "d4", sel4, nib4, dp4, blank4, tick4, frame4);
    cmp_inst(1, "d1", sel1, nib1, dp1, blank1, tick1, frame1);
  end

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_sel4"},   32'(sel4), 0);   chk({nm, "_sel1"},   32'(sel1), 0);
    chk({nm, "_nib4"},   32'(nib4), 0);   chk({nm, "_nib1"},   32'(nib1), 0);
    chk({nm, "_dp4"},    32'(dp4), 0);    chk({nm, "_dp1"},    32'(dp1), 0);
    chk({nm, "_blank4"}, 32'(blank4), 1); chk({nm, "_blank1"}, 32'(blank1), 1);
    chk({nm, "_tick4"},  32'(tick4), 0);  chk({nm, "_tick1"},  32'(tick1), 0);
    chk({nm, "_frame4"}, 32'(frame4), 0); chk({nm, "_frame1"}, 32'(frame1), 0);
  endtask

  // Assert reset between edges and check outputs clear before any clock edge.
  task automatic rst_pulse(input string nm);
    #2 rst = 1'b1;
    #1 chk_reset_vals(nm);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int frames;
    int ticks;
    logic [2:0] s;

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");

    // Free-running scan from reset release.
    digits = 32'h76543210;
    en     = 1'b1;
    rst    = 1'b0;
    @(negedge clk);
    frames = 0;
    ticks  = 0;
    for (int c = 0; c < 36; c++) begin
      chk("walk_sel4", 32'(sel4), 32'((c / 4) % 8));
      chk("walk_nib4", 32'(nib4), 32'(sel4));
      chk("walk_sel1", 32'(sel1), 32'(c % 8));
      chk("walk_tick1", 32'(tick1), 1);
      if (c < 32) begin
        frames += int'(frame4);
        ticks  += int'(tick4);
      end
      @(negedge clk);
    end
    chk("frames_per_32", 32'(frames), 1);
    chk("ticks_per_32", 32'(ticks), 8);

    // Pause on digit 3 for 10 cycles, then resume.
    for (int i = 0; i < 64 && sel4 != 3'd3; i++) @(negedge clk);
    chk("wait_sel3", 32'(sel4), 3);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_blank", 32'(blank4), 1);
      chk("idle_sel", 32'(sel4), 3);
    end
    en = 1'b1;
    repeat (4) @(negedge clk);
    chk("resume_hold3", 32'(sel4), 3);
    @(negedge clk);
    chk("resume_sel4", 32'(sel4), 4);

    // en falls in a tick cycle: no advance, blank next cycle.
    for (int i = 0; i < 16 && !tick4; i++) @(negedge clk);
    chk("wait_tick", 32'(tick4), 1);
    s  = sel4;
    en = 1'b0;
    @(negedge clk);
    chk("tickdrop_sel", 32'(sel4), 32'(s));
    chk("tickdrop_blank", 32'(blank4), 1);
    en = 1'b1;

    // Per-digit mask and decimal point.
    blank_mask = 8'h81;
    dp_in      = 8'h04;
    @(negedge clk);
    repeat (2) @(negedge clk);
    for (int c = 0; c < 40; c++) begin
      chk("mask_blank", 32'(blank4), 32'((sel4 == 3'd0) || (sel4 == 3'd7)));
      chk("mask_dp", 32'(dp4), 32'(sel4 == 3'd2));
      @(negedge clk);
    end

`ifdef SEG_SCAN_LZ_BLANK_EN
    blank_mask = 8'h00;
    dp_in      = 8'h00;
    digits     = 32'h00000A05;
    @(negedge clk);
    for (int c = 0; c < 32; c++) begin
      chk("lz_blank", 32'(blank4), 32'(sel4 >= 3'd3));
      @(negedge clk);
    end
    dp_in = 8'h20;
    @(negedge clk);
    for (int c = 0; c < 32; c++) begin
      chk("lz_dp_blank", 32'(blank4), 32'((sel4 >= 3'd3) && (sel4 != 3'd5)));
      @(negedge clk);
    end
`endif

    // Asynchronous reset in the middle of a slot.
    repeat (2) @(negedge clk);
    rst_pulse("midrst");

    // Randomized run with occasional pauses and resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      en = ($urandom_range(0, 11) != 0);
      if ($urandom_range(0, 3) == 0) digits = $urandom;
      if ($urandom_range(0, 7) == 0) dp_in = 8'($urandom);
      if ($urandom_range(0, 7) == 0) blank_mask = 8'($urandom);
      if ($urandom_range(0, 400) == 0) rst_pulse("rand_rst");
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
